// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the mux4x1 select arbiter.
//   N_CH    : number of arbitrated channels (the mux has four inputs)
//   SEL_W   : width of the mux select
//   state_t : arbiter FSM encoding (IDLE / GRANT / GAP)
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker.
// The request vector is rotated so that the channel after last_ptr sits in bit
// 0. The rotated vector is priority-encoded (lowest set bit wins), and the
// winning offset is then mapped back to a channel number.
// Ports:
//   req      in  [3:0]  channel requests
//   last_ptr in  [1:0]  most recently served channel (lowest priority)
//   winner   out [1:0]  channel chosen for the next grant
//   any_req  out        at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic [N_CH-1:0]  rot_req;
  logic [SEL_W-1:0] offset;

  // rot_req[gi] is the channel that is gi+1 places after last_ptr.
  // The 2-bit addition wraps modulo 4.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rot
      logic [SEL_W-1:0] src_idx;
      assign src_idx     = last_ptr + SEL_W'(gi + 1);
      assign rot_req[gi] = req[src_idx];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot_req[j]) offset = SEL_W'(j);
    end
  end

  assign winner  = last_ptr + offset + SEL_W'(1);
  assign any_req = |req;

endmodule : rr_pick

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin arbiter that generates the 2-bit select of mux4x1. One channel
// is granted at a time. sel is held for the whole grant. Every grant is
// followed by a mandatory one-cycle GAP before the next arbitration.
// Optional feature (define MUX_SEL_ARB_TIMEOUT_EN): a grant is forcibly
// released after MAX_HOLD cycles, and timeout pulses for that cycle.
// Ports:
//   clk     in         rising-edge clock
//   rst_n   in         asynchronous active-low reset
//   req     in  [3:0]  level-sensitive channel requests
//   sel     out [1:0]  registered mux select
//   grant   out [3:0]  registered one-hot grant (1<<sel while busy, else 0)
//   busy    out        a grant is active
//   timeout out        one-cycle pulse on a forced release (0 if compiled out)
// -----------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             busy,
  output logic             timeout
);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_sel_arbiter: MAX_HOLD must be within 2..255");
    end
  endgenerate

  state_t           state_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] last_ptr_reg;
  logic [N_CH-1:0]  grant_reg;
  logic             busy_reg;
  logic [SEL_W-1:0] winner;
  logic             any_req;

  rr_pick u_rr_pick (
    .req      (req),
    .last_ptr (last_ptr_reg),
    .winner   (winner),
    .any_req  (any_req)
  );

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg;
  logic       timeout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      last_ptr_reg <= 2'b11;
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_reg      <= winner;
            grant_reg    <= N_CH'(1) << winner;
            busy_reg     <= 1'b1;
            hold_cnt_reg <= '0;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          // A voluntary release takes precedence. The forced release looks
          // identical to it, apart from the timeout pulse.
          if (!req[sel_reg] || hold_cnt_reg == 8'(MAX_HOLD - 1)) begin
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            last_ptr_reg <= sel_reg;
            state_reg    <= GAP;
            timeout_reg  <= req[sel_reg];
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout = timeout_reg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      last_ptr_reg <= 2'b11;
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_reg   <= winner;
            grant_reg <= N_CH'(1) << winner;
            busy_reg  <= 1'b1;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (!req[sel_reg]) begin
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            last_ptr_reg <= sel_reg;
            state_reg    <= GAP;
          end
        end
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign sel   = sel_reg;
  assign grant = grant_reg;
  assign busy  = busy_reg;

endmodule : mux_sel_arbiter

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Directed testbench for mux_sel_arbiter, built with MAX_HOLD=4.
// Every check compares {sel, grant, busy, timeout} with a hand-derived value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_v;

  mux_sel_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle. Prints one line per cycle.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t req=%b sel=%0d grant=%b busy=%b timeout=%b",
             $time, req, sel, grant, busy, timeout);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      exp_v = {2'd0, 4'b0000, 1'b0, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = {2'd2, 4'b0100, 1'b1, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL single_hold[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
    req = 4'b0000;
    step();
    exp_v = {2'd2, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL single_release: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL single_gap: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 2; c++) begin
        step();
        exp_v = {order[i], 4'b0001 << order[i], 1'b1, 1'b0};
        n_cmp++;
        if ({sel, grant, busy, timeout} !== exp_v) begin
          n_bad++;
          $display("FAIL rr_grant[%0d.%0d]: got %b want %b", i, c, {sel, grant, busy, timeout}, exp_v);
        end
      end
      req = 4'b1111 & ~(4'b0001 << order[i]);
      step();
      exp_v = {order[i], 4'b0000, 1'b0, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL rr_release[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
      req = 4'b1111;
      step();
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL rr_gap[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_hold_mid_request();
    apply_reset();
    req = 4'b0010;
    step();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      exp_v = {2'd1, 4'b0010, 1'b1, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL hold_owner[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
    req = 4'b1000;
    step();
    exp_v = {2'd1, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL hold_release: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL hold_gap: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd3, 4'b1000, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL hold_next: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // Single-cycle request, then the owner drops while another channel rises.
  task automatic test_back_to_back();
    apply_reset();
    req = 4'b1000;
    step();
    req = 4'b0000;
    exp_v = {2'd3, 4'b1000, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL pulse_grant: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd3, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL pulse_release: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    req = 4'b0001;
    step();
    step();
    req = 4'b0100;
    exp_v = {2'd0, 4'b0001, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL swap_owner: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd0, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL swap_release: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL swap_gap: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd2, 4'b0100, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL swap_new: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b0100;
    step();
    step();
    rst_n = 1'b0;
    #1;
    exp_v = {2'd0, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL async_reset: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0101;
    step();
    exp_v = {2'd0, 4'b0001, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL post_reset_prio: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0011;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = {2'd0, 4'b0001, 1'b1, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL to_hold[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
    step();
    exp_v = {2'd0, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL to_pulse: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd0, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL to_gap: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
    step();
    exp_v = {2'd1, 4'b0010, 1'b1, 1'b0};
    n_cmp++;
    if ({sel, grant, busy, timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL to_next: got %b want %b", {sel, grant, busy, timeout}, exp_v);
    end
`else
    for (int i = 0; i < 12; i++) begin
      step();
      exp_v = {2'd0, 4'b0001, 1'b1, 1'b0};
      n_cmp++;
      if ({sel, grant, busy, timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL no_to_hold[%0d]: got %b want %b", i, {sel, grant, busy, timeout}, exp_v);
      end
    end
`endif
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_mid_request();
    test_back_to_back();
    test_reset_mid_grant();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mux_sel_arbiter
